// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART frame parser: FSM states, error codes,
// the default start-of-frame byte and the inter-byte timeout sizing helper.
package uart_frame_parser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_OUT
  } state_t;

  typedef enum logic [1:0] {
    ERR_LEN = 2'd0,
    ERR_CHK = 2'd1,
    ERR_TMO = 2'd2,
    ERR_OVR = 2'd3
  } err_t;

  localparam logic [7:0] DEFAULT_SOF = 8'hAA;

  // Inter-byte timeout in clocks: whole clocks per bit times the bit budget.
  function automatic int unsigned timeout_clks(input int unsigned clkfreq,
                                               input int unsigned baudrate,
                                               input int unsigned bits);
    return (clkfreq / baudrate) * bits;
  endfunction

endpackage

// File: rtl/uart_frame_parser_buf.sv
// Payload buffer for the frame parser: c_depth x 8 register array with one
// synchronous write port and one asynchronous read port.
// Ports:
//   clk   in   clock
//   we    in   write enable
//   waddr in   write address (c_aw bits)
//   wdata in   write data
//   raddr in   read address (c_aw bits)
//   rdata out  read data, combinational from raddr
module uart_frame_buf #(
  parameter int unsigned c_depth = 16,
  parameter int unsigned c_aw    = 5
) (
  input  logic            clk,
  input  logic            we,
  input  logic [c_aw-1:0] waddr,
  input  logic [7:0]      wdata,
  input  logic [c_aw-1:0] raddr,
  output logic [7:0]      rdata
);

  logic [7:0] mem [c_depth];

  // Address decode by comparison keeps out-of-range addresses harmless
  // when c_aw is wider than the array needs.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < c_depth; i++) begin
      if (we && waddr == c_aw'(i)) mem[i] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < c_depth; i++) begin
      if (raddr == c_aw'(i)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser behind a UART receiver. Extracts SOF, LEN, LEN payload bytes,
// CHK frames from a byte strobe stream, buffers valid payloads and streams
// them out on a valid/ready interface. Bad length, bad checksum, inter-byte
// timeout and overrun (byte arriving while streaming) raise a one-cycle error.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   din_i        received byte
//   din_valid_i  one-cycle byte strobe
//   m_data_o     payload byte out
//   m_valid_o    m_data_o valid
//   m_ready_i    sink ready; transfer on m_valid_o & m_ready_i
//   m_last_o     high with the final payload byte
//   frame_len_o  LEN of the frame being streamed
//   err_o        one-cycle error pulse
//   err_code_o   0 length, 1 checksum, 2 timeout, 3 overrun; held between errors
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int unsigned c_clkfreq      = 100_000_000,
  parameter int unsigned c_baudrate     = 115_200,
  parameter int unsigned c_timeout_bits = 40,
  parameter int unsigned c_max_len      = 16,
  parameter logic [7:0]  c_sof          = DEFAULT_SOF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din_i,
  input  logic       din_valid_i,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic       m_last_o,
  output logic [7:0] frame_len_o,
  output logic       err_o,
  output logic [1:0] err_code_o
);

  localparam int unsigned TMO = timeout_clks(c_clkfreq, c_baudrate, c_timeout_bits);
  localparam int unsigned IW  = $clog2(c_max_len + 1);
  localparam int unsigned TW  = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
  localparam logic [7:0]    MAX_LEN8 = 8'(c_max_len);

  state_t          state, state_n;
  logic [7:0]      len, len_n;
  logic [IW-1:0]   idx, idx_n;
  logic [IW-1:0]   rd_idx, rd_idx_n;
  logic [7:0]      chk, chk_n;
  logic [TW-1:0]   tmo_cnt, tmo_n;
  logic            m_valid, m_valid_n;
  logic [7:0]      m_data, m_data_n;
  logic            m_last, m_last_n;
  logic [7:0]      frame_len, frame_len_n;
  logic            err, err_n;
  err_t            err_code, err_code_n;
  logic            buf_we;
  logic [IW-1:0]   raddr;
  logic [7:0]      rdata;

  uart_frame_buf #(
    .c_depth (c_max_len),
    .c_aw    (IW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx),
    .wdata (din_i),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len       <= '0;
      idx       <= '0;
      rd_idx    <= '0;
      chk       <= '0;
      tmo_cnt   <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      frame_len <= '0;
      err       <= 1'b0;
      err_code  <= ERR_LEN;
    end else begin
      state     <= state_n;
      len       <= len_n;
      idx       <= idx_n;
      rd_idx    <= rd_idx_n;
      chk       <= chk_n;
      tmo_cnt   <= tmo_n;
      m_valid   <= m_valid_n;
      m_data    <= m_data_n;
      m_last    <= m_last_n;
      frame_len <= frame_len_n;
      err       <= err_n;
      err_code  <= err_code_n;
    end
  end

  always_comb begin
    state_n     = state;
    len_n       = len;
    idx_n       = idx;
    rd_idx_n    = rd_idx;
    chk_n       = chk;
    tmo_n       = '0;
    m_valid_n   = m_valid;
    m_data_n    = m_data;
    m_last_n    = m_last;
    frame_len_n = frame_len;
    err_n       = 1'b0;
    err_code_n  = err_code;
    buf_we      = 1'b0;
    raddr       = '0;

    case (state)
      S_IDLE: begin
        if (din_valid_i && din_i == c_sof) state_n = S_LEN;
      end

      S_LEN, S_PAYLOAD, S_CHK: begin
        // A strobe on the expiry cycle takes the normal path below.
        if (!din_valid_i) begin
          if (tmo_cnt == TMO_LAST) begin
            err_n      = 1'b1;
            err_code_n = ERR_TMO;
            state_n    = S_IDLE;
          end else begin
            tmo_n = tmo_cnt + 1'b1;
          end
        end else begin
          case (state)
            S_LEN: begin
              if (din_i == '0 || din_i > MAX_LEN8) begin
                err_n      = 1'b1;
                err_code_n = ERR_LEN;
                state_n    = S_IDLE;
              end else begin
                len_n   = din_i;
                chk_n   = din_i;
                idx_n   = '0;
                state_n = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              buf_we = 1'b1;
              chk_n  = chk + din_i;
              idx_n  = idx + 1'b1;
              if (8'(idx) == len - 8'd1) state_n = S_CHK;
            end
            S_CHK: begin
              if (din_i == chk) begin
                // raddr is 0 here, so the first byte is loaded directly.
                state_n     = S_OUT;
                rd_idx_n    = '0;
                m_valid_n   = 1'b1;
                m_data_n    = rdata;
                m_last_n    = (len == 8'd1);
                frame_len_n = len;
              end else begin
                err_n      = 1'b1;
                err_code_n = ERR_CHK;
                state_n    = S_IDLE;
              end
            end
            default: ;
          endcase
        end
      end

      S_OUT: begin
        raddr = rd_idx + 1'b1;
        if (din_valid_i) begin
          err_n      = 1'b1;
          err_code_n = ERR_OVR;
        end
        if (m_valid && m_ready_i) begin
          if (m_last) begin
            m_valid_n = 1'b0;
            m_last_n  = 1'b0;
            state_n   = S_IDLE;
          end else begin
            rd_idx_n = raddr;
            m_data_n = rdata;
            m_last_n = (8'(raddr) == len - 8'd1);
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign m_data_o    = m_data;
  assign m_valid_o   = m_valid;
  assign m_last_o    = m_last;
  assign frame_len_o = frame_len;
  assign err_o       = err;
  assign err_code_o  = err_code;

endmodule
